// File: rtl/aclk_key_entry_if.sv
// Keypad entry bus: key strobes and commit buttons toward the entry stage,
// and the HH:MM buffer, load strobes and status back toward the user.
interface aclk_key_entry_if;
   logic       key_valid;
   logic [3:0] key;
   logic       alarm_button;
   logic       time_button;
   logic [3:0] key_buffer_ms_hr;
   logic [3:0] key_buffer_ls_hr;
   logic [3:0] key_buffer_ms_min;
   logic [3:0] key_buffer_ls_min;
   logic       load_new_alarm;
   logic       load_new_time;
   logic       entry_error;
   logic       entry_active;

   modport master (
      output key_valid, key, alarm_button, time_button,
      input  key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min,
      input  load_new_alarm, load_new_time, entry_error, entry_active
   );

   modport slave (
      input  key_valid, key, alarm_button, time_button,
      output key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min,
      output load_new_alarm, load_new_time, entry_error, entry_active
   );
endinterface

// File: rtl/aclk_key_entry.sv
// Keypad digit-entry stage: shifts BCD digits into an HH:MM buffer, validates
// it as 24-hour time on ALARM/TIME and issues a one-cycle registered load strobe.
module aclk_key_entry #(
   parameter int TIMEOUT_CYCLES = 10
) (
   input logic              clock,
   input logic              reset,
   aclk_key_entry_if.slave  bus
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic {IDLE, ENTRY} state_t;

   state_t          state_q, state_d;
   logic [3:0][3:0] digits_q, digits_d;  // [3]=ms_hr .. [0]=ls_min
   logic [2:0]      count_q, count_d;
   logic [TW-1:0]   tcount_q, tcount_d;
   logic            load_alarm_q, load_alarm_d;
   logic            load_time_q, load_time_d;
   logic            error_q, error_d;

   logic is_digit, any_button, commit_ok;

   assign is_digit   = bus.key_valid && (bus.key <= 4'd9);
   assign any_button = bus.alarm_button || bus.time_button;
   assign commit_ok  = (bus.alarm_button ^ bus.time_button) && (count_q == 3'd4) &&
                       (digits_q[3] <= 4'd2) &&
                       ((digits_q[3] < 4'd2) || (digits_q[2] <= 4'd3)) &&
                       (digits_q[1] <= 4'd5);

   // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d      = state_q;
      digits_d     = digits_q;
      count_d      = count_q;
      tcount_d     = tcount_q;
      load_alarm_d = 1'b0;
      load_time_d  = 1'b0;
      error_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_digit) begin
               digits_d = {12'h000, bus.key};
               count_d  = 3'd1;
               tcount_d = '0;
               state_d  = ENTRY;
            end
         end
         ENTRY: begin
            if (any_button) begin
               // A button wins over a same-cycle digit; the buffer only survives a valid commit.
               state_d  = IDLE;
               count_d  = 3'd0;
               tcount_d = '0;
               if (commit_ok) begin
                  load_alarm_d = bus.alarm_button;
                  load_time_d  = bus.time_button;
               end else begin
                  error_d  = 1'b1;
                  digits_d = '0;
               end
            end else if (is_digit) begin
               digits_d = {digits_q[2:0], bus.key};
               count_d  = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
               tcount_d = '0;
            end else if (tcount_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d  = IDLE;
               digits_d = '0;
               count_d  = 3'd0;
               tcount_d = '0;
            end else begin
               tcount_d = tcount_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         digits_q     <= '0;
         count_q      <= 3'd0;
         tcount_q     <= '0;
         load_alarm_q <= 1'b0;
         load_time_q  <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         digits_q     <= digits_d;
         count_q      <= count_d;
         tcount_q     <= tcount_d;
         load_alarm_q <= load_alarm_d;
         load_time_q  <= load_time_d;
         error_q      <= error_d;
      end
   end

   assign bus.key_buffer_ms_hr  = digits_q[3];
   assign bus.key_buffer_ls_hr  = digits_q[2];
   assign bus.key_buffer_ms_min = digits_q[1];
   assign bus.key_buffer_ls_min = digits_q[0];
   assign bus.load_new_alarm    = load_alarm_q;
   assign bus.load_new_time     = load_time_q;
   assign bus.entry_error       = error_q;
   assign bus.entry_active      = (state_q == ENTRY);

endmodule

// File: tb/tb_aclk_key_entry.sv
// Self-checking bench for aclk_key_entry: directed scenarios plus random stimulus
// against a reference model that treats the buffer as a decimal HHMM number.
module tb_aclk_key_entry;

   localparam int T = 10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model state
   bit m_active;
   int m_val;      // buffer as a decimal number 0..9999
   int m_cnt;
   int m_idle;
   bit m_la, m_lt, m_err;

   aclk_key_entry_if bus ();

   aclk_key_entry #(.TIMEOUT_CYCLES(T)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // {ms_hr, ls_hr, ms_min, ls_min, load_alarm, load_time, error, active}
   function automatic logic [19:0] dut_vec();
      return {bus.key_buffer_ms_hr, bus.key_buffer_ls_hr, bus.key_buffer_ms_min,
              bus.key_buffer_ls_min, bus.load_new_alarm, bus.load_new_time,
              bus.entry_error, bus.entry_active};
   endfunction

   function automatic logic [19:0] model_vec();
      logic [3:0] d3, d2, d1, d0;
      d3 = 4'(m_val / 1000);
      d2 = 4'((m_val / 100) % 10);
      d1 = 4'((m_val / 10) % 10);
      d0 = 4'(m_val % 10);
      return {d3, d2, d1, d0, m_la, m_lt, m_err, m_active};
   endfunction

   function automatic logic [15:0] buf_bcd();
      return dut_vec()[19:4];
   endfunction

   task automatic model_update(input bit r, input bit kv, input int k, input bit ab, input bit tb);
      bit digit;
      digit = kv && (k <= 9);
      m_la = 0; m_lt = 0; m_err = 0;
      if (r) begin
         m_active = 0; m_val = 0; m_cnt = 0; m_idle = 0;
      end else if (!m_active) begin
         if (digit) begin
            m_val = k; m_cnt = 1; m_idle = 0; m_active = 1;
         end
      end else if (ab || tb) begin
         if ((ab != tb) && m_cnt == 4 && (m_val / 100) < 24 && (m_val % 100) < 60) begin
            m_la = ab; m_lt = tb;
         end else begin
            m_err = 1; m_val = 0;
         end
         m_active = 0; m_cnt = 0; m_idle = 0;
      end else if (digit) begin
         m_val  = (m_val * 10 + k) % 10000;
         m_cnt  = (m_cnt < 4) ? m_cnt + 1 : 4;
         m_idle = 0;
      end else begin
         m_idle++;
         if (m_idle >= T) begin
            m_val = 0; m_cnt = 0; m_active = 0; m_idle = 0;
         end
      end
   endtask

   task automatic step(input bit r, input bit kv, input logic [3:0] k, input bit ab, input bit tb);
      rst              = r;
      bus.key_valid    = kv;
      bus.key          = k;
      bus.alarm_button = ab;
      bus.time_button  = tb;
      @(posedge clk);
      model_update(r, kv, int'(k), ab, tb);
      #1;
      check("outputs", 32'(dut_vec()), 32'(model_vec()));
      check("strobe_excl",
            32'($countones({bus.load_new_alarm, bus.load_new_time, bus.entry_error}) <= 1), 32'd1);
   endtask

   task automatic press(input logic [3:0] k);
      step(1'b0, 1'b1, k, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   initial begin
      bus.key_valid = 0; bus.key = 0; bus.alarm_button = 0; bus.time_button = 0;
      #2;

      // T1: reset with random inputs
      for (int i = 0; i < 2; i++)
         step(1'b1, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      check("t1_reset", 32'(dut_vec()), 32'd0);

      // T2: 12:30 alarm
      press(1); press(2); press(3); press(0);
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      check("t2_buf", 32'(buf_bcd()), 32'h1230);
      check("t2_load", 32'({bus.load_new_alarm, bus.load_new_time, bus.entry_error}), 32'b100);
      idle(1);
      check("t2_after", 32'({bus.load_new_alarm, bus.entry_active, buf_bcd()}), 32'h1230);

      // T3: 24:00 rejected
      press(2); press(4); press(0); press(0);
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      check("t3_err", 32'({bus.load_new_alarm, bus.load_new_time, bus.entry_error}), 32'b001);
      check("t3_buf", 32'(buf_bcd()), 32'h0000);
      idle(1);

      // T4: only last four digits kept, 04:56 time
      press(1); press(0); press(4); press(5); press(6);
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      check("t4_buf", 32'(buf_bcd()), 32'h0456);
      check("t4_load", 32'({bus.load_new_alarm, bus.load_new_time, bus.entry_error}), 32'b010);
      idle(1);

      // T5: timeout boundary, then short entry rejected
      press(1); press(2);
      idle(T - 1);
      check("t5_still_active", 32'(bus.entry_active), 32'd1);
      idle(1);
      check("t5_timeout", 32'({bus.entry_active, bus.load_new_alarm, bus.load_new_time,
                               bus.entry_error, buf_bcd()}), 32'h0);
      press(3); press(4); press(5);
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      check("t5_short_err", 32'(bus.entry_error), 32'd1);
      idle(1);

      // T6: reset mid-entry, then 08:40 with an ignored non-digit key
      press(0); press(8);
      step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      check("t6_reset", 32'({bus.entry_active, buf_bcd()}), 32'h0);
      press(0); press(8); press(12); press(4); press(0);
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      check("t6_buf", 32'(buf_bcd()), 32'h0840);
      check("t6_load", 32'(bus.load_new_alarm), 32'd1);
      idle(1);

      // Both buttons and a button with a digit in the same cycle
      press(1); press(1); press(1); press(1);
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      check("both_buttons", 32'({bus.entry_error, buf_bcd()}), 32'h10000);
      press(2); press(3); press(5); press(9);
      step(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
      check("button_drops_key", 32'({bus.load_new_time, buf_bcd()}), 32'h12359);
      idle(1);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         automatic int  r  = $urandom_range(0, 99);
         automatic bit  kv = ($urandom_range(0, 99) < 55);
         automatic logic [3:0] k = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                                : 4'($urandom_range(0, 9));
         automatic int  b  = $urandom_range(0, 99);
         step(r == 0, kv, k, (b < 6) || (b == 99), (b >= 6 && b < 12) || (b == 99));
         if ($urandom_range(0, 49) == 0) idle($urandom_range(1, T + 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
